// File: rtl/mem_pkg.sv
// Shared constants and FSM state encoding for the table loader.
package mem_pkg;

   localparam int DATA_W = 4;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/ram_1w1r.sv
// Single-write / single-read RAM with a registered, read-before-write read port.
module ram_1w1r #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Array write port.
   // NOTE: the storage array has no reset so it maps onto plain RAM cells;
   // a loaded table survives a controller reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read; sampling mem before the write lands gives read-before-write.
   // NOTE: non-blocking assignments here are what make the same-cycle read see
   // the old word -- a blocking write would race the read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/mem_writer.sv
// Loads a run of stream words into the table RAM starting at a base address;
// the read port behaves exactly like the lookup ROM (one-cycle latency).
module mem_writer
   import mem_pkg::*;
#(
   parameter int DATA_W = mem_pkg::DATA_W,
   parameter int ADDR_W = mem_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   wr_count,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W:0]   remaining;
   logic              xfer;
   logic              we;

   assign xfer = in_valid & in_ready;
   // Reset wins over an in-flight transfer: nothing reaches the array that cycle.
   assign we   = xfer & ~rst;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and state-decoded outputs.
   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = (count != '0) ? WRITE : DONE;
            end
         end
         WRITE: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && remaining == (ADDR_W + 1)'(1)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Load bookkeeping: write pointer (wraps modulo DEPTH), words left, words written.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         remaining <= '0;
         wr_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  wr_ptr    <= base_addr;
                  remaining <= count;
                  wr_count  <= '0;
               end
            end
            WRITE: begin
               if (xfer) begin
                  wr_ptr    <= wr_ptr + ADDR_W'(1);
                  remaining <= remaining - (ADDR_W + 1)'(1);
                  wr_count  <= wr_count + (ADDR_W + 1)'(1);
               end
            end
            default: ;
         endcase
      end
   end

   ram_1w1r #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: doc/mem_writer.md
# mem_writer

Write-side companion to the team's synchronous lookup ROM. Loads a run of words from a valid/ready stream into an internal 16×4 single-write/single-read RAM, starting at a programmable base address. It exposes a registered read port with the same one-cycle latency as the ROM, so existing ROM consumers can read the loaded table unchanged. It sits between a configuration/data source (UART loader, test controller) and the table consumers.

## Interface
- DATA_W, default 4: word width.
- ADDR_W, default 4: address width; DEPTH = 2**ADDR_W = 16.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address, captured with start.
- count  in  ADDR_W+1  number of words to write, 0..DEPTH, captured with start.
- in_data  in  DATA_W  stream word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle pulse when the load completes.
- wr_count  out  ADDR_W+1  words written in the current or last load.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE: in_ready=0, busy=0. On start=1: capture base_addr into wr_ptr and count into remaining, clear wr_count. Go to WRITE if count≠0; otherwise go to DONE.
- WRITE: in_ready=1, busy=1.
  - Each cycle with in_valid & in_ready: RAM[wr_ptr] <= in_data, wr_ptr <= wr_ptr+1, remaining -= 1, wr_count += 1.
  - On the transfer that takes remaining to 0, go to DONE.
  - in_valid=0 stalls indefinitely with no timeout.
- DONE: done=1 and busy=1 for exactly one cycle; in_ready=0. Then go to IDLE.
- Address wrap-around: wr_ptr increments modulo DEPTH. For example, base 14 with count 4 writes addresses 14, 15, 0, 1. When count=DEPTH, every location is written exactly once.
- start is ignored outside IDLE. A start in the DONE cycle is also ignored.
- Read port: rd_data <= RAM[rd_addr] on every clock, independent of FSM state.
- Read and write to the same address in the same cycle: the read returns the old data (read-before-write).
- Reset:
  - Outputs reset to: in_ready=0, busy=0, done=0, wr_count=0, rd_data=0.
  - FSM returns to IDLE; wr_ptr and remaining are cleared.
  - RAM contents are not cleared by reset.
  - Reset mid-load abandons the load. Words already written stay in RAM, and no done pulse is issued.
  - rst has priority over start and in_valid in the same cycle.

## Timing
- start accepted at edge N: busy=1 and in_ready=1 from cycle N+1.
- The write completes at the accepting edge. A read of that address issued in the next cycle shows the new data one edge later, so write-to-read visibility is 2 cycles.
- The last transfer at edge M gives done=1 during cycle M+1, and IDLE from cycle M+2.
- count=0: start at edge N gives done=1 during cycle N+1, with no writes and wr_count=0.
- Peak throughput: one word per cycle with in_valid held high. A load of k words takes k+2 cycles from start to IDLE.
- rd_data latency: 1 cycle, matching the ROM.

## Structure
- Shared package mem_pkg holds DATA_W, ADDR_W, DEPTH and the FSM state enum (IDLE, WRITE, DONE).
- Sub-module ram_1w1r: a 16×4 array with a write-enable port and a registered read port implementing read-before-write. It has no reset on the array; only rd_data is reset.
- mem_writer contains the FSM, wr_ptr, remaining and wr_count, and instantiates ram_1w1r.

## Test plan
- Reset, then base=0, count=16, data 0..F with in_valid held high: done in cycle 17 after start, wr_count=16, reading addresses 0..F returns 0..F with 1-cycle latency.
- base=14, count=4, data A,B,C,D: addresses 14, 15, 0, 1 read A, B, C, D; address 2 is unchanged.
- count=0: done is pulsed one cycle after start, no RAM location changes, wr_count=0.
- count=3 with in_valid toggling 1,0,0,1,0,1: exactly 3 writes, in_ready stays high throughout WRITE, done follows the third transfer by one cycle; a second start while busy is ignored.
- Same-cycle read and write to address 5 (old value 3, new value 9): rd_data=3 next cycle and 9 on the following read.
- rst asserted after 2 of 5 words: FSM returns to IDLE with busy=0, no done pulse, the 2 written words persist and the rest of RAM is unchanged.
